// File: rtl/fp16_pkg.sv
// Shared fp16 definitions for the multiplier arbiter and its clients.
package fp16_pkg;

  localparam int FP_W = 16;

  typedef logic [FP_W-1:0] fp16_t;

  localparam fp16_t FP16_ONE = 16'h3C00;
  localparam fp16_t FP16_TWO = 16'h4000;

endpackage

// File: rtl/rr_arbiter.sv
// Generic round-robin arbiter: searches upward from an internal pointer with
// wrap, returns a one-hot grant plus its index, and moves the pointer one past
// the winner only when the caller strobes i_advance.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_advance,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_grant_idx
);

  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_cand;
  logic             w_found;

  // Modulo-NUM_REQ add that also works when NUM_REQ is not a power of two.
  function automatic int wrap_idx(input int base, input int off);
    int sum;
    sum = base + off;
    return (sum >= NUM_REQ) ? sum - NUM_REQ : sum;
  endfunction

  // Priority search starting at r_ptr; the first requesting slot wins.
  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    o_grant     = '0;
    o_grant_idx = '0;
    w_cand      = '0;
    w_found     = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = IDX_W'(wrap_idx(int'(r_ptr), k));
      if (!w_found && i_req[w_cand]) begin
        w_found          = 1'b1;
        o_grant[w_cand]  = 1'b1;
        o_grant_idx      = w_cand;
      end
    end
  end

  // Pointer moves one past the winner, and only on an actual grant.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of statement order.
    if (rst) begin
      r_ptr <= '0;
    end else if (i_advance) begin
      r_ptr <= IDX_W'(wrap_idx(int'(o_grant_idx), 1));
    end
  end

endmodule

// File: rtl/fp16_mul_arbiter.sv
// Shares one fixed-latency fp16 multiplier among NUM_REQ requesters. Grants
// round-robin, drives the multiplier operands, carries the requester tag
// alongside the multiplier pipeline and parks each result in a per-requester
// response register until the requester consumes it.
module fp16_mul_arbiter
  import fp16_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int MUL_LATENCY = 1,
  parameter int FP_W        = fp16_pkg::FP_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*FP_W-1:0] req_a,
  input  logic [NUM_REQ*FP_W-1:0] req_b,
  output logic [NUM_REQ-1:0]      rsp_valid,
  input  logic [NUM_REQ-1:0]      rsp_ready,
  output logic [NUM_REQ*FP_W-1:0] rsp_data,
  output logic [FP_W-1:0]         mul_in1,
  output logic [FP_W-1:0]         mul_in2,
  input  logic [FP_W-1:0]         mul_result,
  output logic                    idle
);

  localparam int TAG_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]                r_busy;
  logic [NUM_REQ-1:0]                w_elig;
  logic [NUM_REQ-1:0]                w_grant;
  logic [TAG_W-1:0]                  w_grant_idx;
  logic                              w_accept;
  logic [NUM_REQ-1:0]                w_rsp_hs;
  logic [NUM_REQ-1:0][FP_W-1:0]      w_req_a;
  logic [NUM_REQ-1:0][FP_W-1:0]      w_req_b;
  logic [MUL_LATENCY-1:0]            r_pipe_vld;
  logic [MUL_LATENCY-1:0][TAG_W-1:0] r_pipe_tag;
  logic                              w_cap_vld;
  logic [TAG_W-1:0]                  w_cap_tag;
  logic [NUM_REQ-1:0]                r_rsp_valid;
  logic [NUM_REQ-1:0][FP_W-1:0]      r_rsp_data;

  assign w_req_a = req_a;
  assign w_req_b = req_b;

  // A requester with a result pending or in flight may not issue again; reset
  // also masks eligibility so req_ready drops the moment rst rises.
  assign w_elig   = req_valid & ~r_busy & {NUM_REQ{~rst}};
  assign w_accept = |w_grant;
  assign w_rsp_hs = r_rsp_valid & rsp_ready;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (TAG_W)
  ) u_rr_arbiter (
    .clk         (clk),
    .rst         (rst),
    .i_req       (w_elig),
    .i_advance   (w_accept),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx)
  );

  assign req_ready = w_grant;

  // Operand mux: the granted requester's operands, zero when nothing issues.
  always_comb begin
    mul_in1 = '0;
    mul_in2 = '0;
    if (w_accept) begin
      mul_in1 = w_req_a[w_grant_idx];
      mul_in2 = w_req_b[w_grant_idx];
    end
  end

  // Busy is set on issue and cleared by the response handshake; the two never
  // coincide for one requester because issue requires busy to be clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= (r_busy | w_grant) & ~w_rsp_hs;
    end
  end

  // Tag pipeline mirrors the multiplier depth; it never stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pipe_vld <= '0;
      r_pipe_tag <= '0;
    end else begin
      r_pipe_vld[0] <= w_accept;
      r_pipe_tag[0] <= w_grant_idx;
      for (int s = 1; s < MUL_LATENCY; s++) begin
        r_pipe_vld[s] <= r_pipe_vld[s-1];
        r_pipe_tag[s] <= r_pipe_tag[s-1];
      end
    end
  end

  assign w_cap_vld = r_pipe_vld[MUL_LATENCY-1];
  assign w_cap_tag = r_pipe_tag[MUL_LATENCY-1];

  // Response slots: capture the multiplier output for the tag leaving the
  // pipeline, clear valid on handshake; data holds until overwritten.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid <= '0;
      // NOTE: the result registers are data storage but are still reset, so no
      // stale value from before reset can ever be presented.
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= r_rsp_valid & ~w_rsp_hs;
      if (w_cap_vld) begin
        r_rsp_valid[w_cap_tag] <= 1'b1;
        r_rsp_data[w_cap_tag]  <= mul_result;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign idle      = ~|r_busy;

endmodule

// File: tb/tb_fp16_mul_arbiter.sv
// Directed bench for fp16_mul_arbiter: one instance with a 1-cycle multiplier
// stub, one with a 3-stage stub. Inputs change just after the falling edge and
// outputs are sampled 1 ns later, well away from the rising edge.
module tb_fp16_mul_arbiter;
  import fp16_pkg::*;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Instance A: MUL_LATENCY = 1
  logic [N-1:0]    a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready;
  logic [N*16-1:0] a_req_a, a_req_b, a_rsp_data;
  logic [15:0]     a_mul_in1, a_mul_in2, a_mul_result;
  logic            a_idle;

  // Instance B: MUL_LATENCY = 3
  logic [N-1:0]    b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready;
  logic [N*16-1:0] b_req_a, b_req_b, b_rsp_data;
  logic [15:0]     b_mul_in1, b_mul_in2, b_mul_result;
  logic            b_idle;
  logic [15:0]     b_s1, b_s2;

  fp16_mul_arbiter #(.NUM_REQ(N), .MUL_LATENCY(1)) u_dut_a (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_a(a_req_a), .req_b(a_req_b),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_data(a_rsp_data),
    .mul_in1(a_mul_in1), .mul_in2(a_mul_in2), .mul_result(a_mul_result),
    .idle(a_idle)
  );

  fp16_mul_arbiter #(.NUM_REQ(N), .MUL_LATENCY(3)) u_dut_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_a(b_req_a), .req_b(b_req_b),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data),
    .mul_in1(b_mul_in1), .mul_in2(b_mul_in2), .mul_result(b_mul_result),
    .idle(b_idle)
  );

  // Multiplier stub: hand-computed products for the directed operand pairs.
  function automatic fp16_t mul_stub(input fp16_t x, input fp16_t y);
    case ({x, y})
      32'h3C004000: return 16'h4000;  // 1.0 * 2.0  = 2.0
      32'h42004400: return 16'h4A00;  // 3.0 * 4.0  = 12.0
      32'hC0003800: return 16'hBC00;  // -2.0 * 0.5 = -1.0
      32'h42004200: return 16'h4880;  // 3.0 * 3.0  = 9.0
      default:      return x ^ y;
    endcase
  endfunction

  always @(posedge clk) a_mul_result <= mul_stub(a_mul_in1, a_mul_in2);

  always @(posedge clk) begin
    b_s1         <= mul_stub(b_mul_in1, b_mul_in2);
    b_s2         <= b_s1;
    b_mul_result <= b_s2;
  end

  fp16_t op_a  [N] = '{16'h4200, 16'hC000, 16'h3C00, 16'h4200};
  fp16_t op_b  [N] = '{16'h4400, 16'h3800, 16'h4000, 16'h4200};
  fp16_t exp_p [N] = '{16'h4A00, 16'hBC00, 16'h4000, 16'h4880};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    a_req_valid = '0; a_rsp_ready = '0;
    b_req_valid = '0; b_rsp_ready = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int others;
    int last_g [N];
    int waitc  [N];
    logic elig;

    rst = 1'b1;
    a_req_valid = '0; a_rsp_ready = '0; a_req_a = '0; a_req_b = '0;
    b_req_valid = '0; b_rsp_ready = '0; b_req_a = '0; b_req_b = '0;

    // Reset state
    @(negedge clk); #1;
    check("rst_rsp_valid", a_rsp_valid, 0);
    check("rst_req_ready", a_req_ready, 0);
    check("rst_rsp_data",  a_rsp_data,  0);
    check("rst_idle",      a_idle,      1);
    rst = 1'b0;

    // 1: single op, 1.0 * 2.0
    @(negedge clk);
    a_rsp_ready = '1;
    a_req_a[15:0] = FP16_ONE; a_req_b[15:0] = FP16_TWO;
    a_req_valid = 4'b0001;
    #1;
    check("t1_ready", a_req_ready, 4'b0001);
    check("t1_in1",   a_mul_in1,   FP16_ONE);
    check("t1_in2",   a_mul_in2,   FP16_TWO);
    @(negedge clk); #1;
    check("t1_busy_ready", a_req_ready, 0);
    check("t1_rsp_early",  a_rsp_valid, 0);
    check("t1_not_idle",   a_idle,      0);
    @(negedge clk);
    a_req_valid = '0;
    #1;
    check("t1_rsp_valid", a_rsp_valid, 4'b0001);
    check("t1_rsp_data",  a_rsp_data[15:0], 16'h4000);
    @(negedge clk); #1;
    check("t1_rsp_clear", a_rsp_valid, 0);
    check("t1_idle",      a_idle,      1);

    // 2: all four after reset, grants 0,1,2,3, responses two cycles later
    do_reset();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      a_req_a[i*16 +: 16] = op_a[i];
      a_req_b[i*16 +: 16] = op_b[i];
    end
    a_rsp_ready = '1;
    a_req_valid = 4'b1111;
    for (int t = 0; t < 6; t++) begin
      if (t > 0) begin
        @(negedge clk);
        if (t <= N) a_req_valid[t-1] = 1'b0;
      end
      #1;
      check($sformatf("t2_ready_c%0d", t), a_req_ready, (t < N) ? (64'd1 << t) : 64'd0);
      if (t < N) check($sformatf("t2_in1_c%0d", t), a_mul_in1, op_a[t]);
      check($sformatf("t2_rsp_valid_c%0d", t), a_rsp_valid, (t >= 2) ? (64'd1 << (t-2)) : 64'd0);
      if (t >= 2) check($sformatf("t2_rsp_data%0d", t-2), a_rsp_data[(t-2)*16 +: 16], exp_p[t-2]);
    end

    // 3: requester 1 holds its result; the others keep the multiplier busy
    @(negedge clk);
    a_rsp_ready = 4'b1101;
    a_req_a[16 +: 16] = 16'hC000; a_req_b[16 +: 16] = 16'h3800;
    a_req_valid = 4'b0010;
    #1;
    check("t3_first_grant", a_req_ready, 4'b0010);
    others = 0;
    for (int t = 1; t <= 8; t++) begin
      @(negedge clk);
      a_req_valid = 4'b1111;
      a_req_a[16 +: 16] = 16'h4200; a_req_b[16 +: 16] = 16'h4200;
      #1;
      check($sformatf("t3_r1_blocked_c%0d", t), a_req_ready[1], 0);
      if ((a_req_ready & 4'b1101) != 0) others++;
      if (t >= 2) check($sformatf("t3_r1_held_c%0d", t), a_rsp_valid[1], 1);
      if (t == 2) check("t3_r1_data", a_rsp_data[16 +: 16], 16'hBC00);
    end
    check("t3_others_served", others, 8);
    @(negedge clk);
    a_req_valid = 4'b0010;
    #1;
    check("t3_no_grant",    a_req_ready, 0);
    check("t3_zero_in1",    a_mul_in1,   0);
    check("t3_still_held",  a_rsp_valid[1], 1);
    @(negedge clk);
    a_rsp_ready = 4'b1111;
    #1;
    check("t3_hs_cycle_ready", a_req_ready, 0);
    @(negedge clk); #1;
    check("t3_regrant",    a_req_ready, 4'b0010);
    check("t3_rsp_cleared", a_rsp_valid[1], 0);
    check("t3_regrant_in1", a_mul_in1, 16'h4200);
    @(negedge clk);
    a_req_valid = '0;
    @(negedge clk); #1;
    check("t3_new_rsp",  a_rsp_valid, 4'b0010);
    check("t3_new_data", a_rsp_data[16 +: 16], 16'h4880);

    // 4a: pointer holds while idle (it sits at 2, so 0 beats 1)
    repeat (3) @(negedge clk);
    a_req_valid = 4'b0011;
    #1;
    check("t4_ptr_hold", a_req_ready, 4'b0001);
    @(negedge clk);
    a_req_valid = '0;
    repeat (4) @(negedge clk);

    // 4b: 0 and 2 always requesting, 1 and 3 stall at random
    for (int k = 0; k < N; k++) begin
      last_g[k] = -100;
      waitc[k]  = 0;
    end
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      a_req_valid = {1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)), 1'b1};
      a_rsp_ready = {1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)), 1'b1};
      #1;
      check("t4_onehot", $onehot0(a_req_ready), 1);
      check("t4_no_spurious", a_req_ready & ~a_req_valid, 0);
      for (int k = 0; k < N; k += 2) begin
        elig = (cyc >= last_g[k] + 3);
        if (a_req_ready[k]) begin
          check($sformatf("t4_early%0d", k), elig, 1);
          check($sformatf("t4_fair%0d", k), waitc[k] <= N, 1);
          waitc[k]  = 0;
          last_g[k] = cyc;
        end else if (elig && a_req_ready != 0) begin
          waitc[k]++;
        end
      end
    end
    check("t4_fair_end0", waitc[0] <= N, 1);
    check("t4_fair_end2", waitc[2] <= N, 1);
    @(negedge clk);
    a_req_valid = '0;
    a_rsp_ready = '1;
    repeat (4) @(negedge clk);
    #1;
    check("t4_drain_idle", a_idle, 1);

    // 5: reset with results held and operations in flight
    @(negedge clk);
    a_rsp_ready = '0;
    a_req_valid = 4'b0001;
    #1; check("t5_g0", a_req_ready, 4'b0001);
    @(negedge clk);
    a_req_valid = 4'b0010;
    #1; check("t5_g1", a_req_ready, 4'b0010);
    @(negedge clk);
    a_req_valid = 4'b0100;
    #1; check("t5_g2", a_req_ready, 4'b0100);
    @(negedge clk);
    a_req_valid = 4'b1000;
    #1; check("t5_held", a_rsp_valid, 4'b0011);
    #1;
    rst = 1'b1;
    #1;
    check("t5_async_rsp_valid", a_rsp_valid, 0);
    check("t5_async_req_ready", a_req_ready, 0);
    check("t5_async_idle",      a_idle,      1);
    check("t5_async_data",      a_rsp_data,  0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    a_req_valid = '0;
    a_rsp_ready = '1;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk); #1;
      check($sformatf("t5_no_phantom_c%0d", t), a_rsp_valid, 0);
      check($sformatf("t5_idle_c%0d", t), a_idle, 1);
    end

    // 6: MUL_LATENCY = 3, back-to-back grants 0,1,2, results at accept+4
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      b_req_a[i*16 +: 16] = op_a[(i == 2) ? 3 : i];
      b_req_b[i*16 +: 16] = op_b[(i == 2) ? 3 : i];
    end
    b_rsp_ready = '1;
    b_req_valid = 4'b0111;
    for (int t = 0; t < 8; t++) begin
      if (t > 0) begin
        @(negedge clk);
        if (t <= 3) b_req_valid[t-1] = 1'b0;
      end
      #1;
      check($sformatf("t6_ready_c%0d", t), b_req_ready, (t < 3) ? (64'd1 << t) : 64'd0);
      check($sformatf("t6_rsp_valid_c%0d", t), b_rsp_valid,
            (t >= 4 && t <= 6) ? (64'd1 << (t-4)) : 64'd0);
      if (t >= 4 && t <= 6)
        check($sformatf("t6_rsp_data%0d", t-4), b_rsp_data[(t-4)*16 +: 16],
              exp_p[(t == 6) ? 3 : t-4]);
    end
    check("t6_idle", b_idle, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
